// File: rtl/aes_round_pipe_if.sv
// Valid/ready bus of the AES round stage: the input beat (state, key, last, tag) and the result beat.
interface aes_round_pipe_if #(
  parameter int TAG_W = 4
) ();
  logic             IN_VALID;
  logic             IN_READY;
  logic [127:0]     IN_DATA;
  logic [127:0]     IN_KEY;
  logic             IN_LAST;
  logic [TAG_W-1:0] IN_TAG;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [127:0]     OUT_DATA;
  logic [TAG_W-1:0] OUT_TAG;

  modport master (
    output IN_VALID, IN_DATA, IN_KEY, IN_LAST, IN_TAG, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA, OUT_TAG
  );

  modport slave (
    input  IN_VALID, IN_DATA, IN_KEY, IN_LAST, IN_TAG, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA, OUT_TAG
  );
endinterface

// File: rtl/aes_round_pipe.sv
// Elastic AES-128 encryption round: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey,
// split over 1..3 register stages with valid/ready flow control, per-beat final-round flag and tag.
module aes_round_pipe #(
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic           clk,
  input  logic           rst,
  aes_round_pipe_if.slave bus
);
  localparam int NS = (PIPE_STAGES < 1) ? 1 : (PIPE_STAGES > 3) ? 3 : PIPE_STAGES;

  if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
    $error("aes_round_pipe: PIPE_STAGES must be 1..3");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_round_pipe: TAG_W must be >= 1");
  end

  typedef enum logic [1:0] {OP_PASS, OP_SBSR, OP_MCARK, OP_FULL} op_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i of the state sits at [127-8i -: 8]; row r of column c is byte 4c+r.
  function automatic logic [127:0] sub_shift(input logic [127:0] d);
    logic [7:0]   b [16];
    logic [127:0] result;
    for (int i = 0; i < 16; i++) b[i] = sbox(d[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        result[127-8*(4*c+r) -: 8] = b[4*((c+r)%4)+r];
    return result;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] d);
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] result;
    for (int c = 0; c < 4; c++) begin
      a0 = d[127-32*c -: 8];
      a1 = d[119-32*c -: 8];
      a2 = d[111-32*c -: 8];
      a3 = d[103-32*c -: 8];
      result[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      result[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      result[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      result[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return result;
  endfunction

  function automatic op_e stage_op(input int i);
    if (NS == 1) return OP_FULL;
    if (NS == 2) return (i == 0) ? OP_SBSR : OP_MCARK;
    return (i == 0) ? OP_PASS : (i == 1) ? OP_SBSR : OP_MCARK;
  endfunction

  function automatic logic [127:0] apply_op(input op_e op, input logic [127:0] d,
                                            input logic [127:0] k, input logic last);
    case (op)
      OP_PASS:  return d;
      OP_SBSR:  return sub_shift(d);
      OP_MCARK: return (last ? d : mix_columns(d)) ^ k;
      default:  return (last ? sub_shift(d) : mix_columns(sub_shift(d))) ^ k;
    endcase
  endfunction

  logic [NS-1:0]    v_q, v_d, en, src_v;
  logic [NS-1:0]    last_q, last_d, src_last;
  logic [127:0]     data_q [NS];
  logic [127:0]     data_d [NS];
  logic [127:0]     key_q  [NS];
  logic [127:0]     key_d  [NS];
  logic [127:0]     src_data [NS];
  logic [127:0]     src_key  [NS];
  logic [TAG_W-1:0] tag_q  [NS];
  logic [TAG_W-1:0] tag_d  [NS];
  logic [TAG_W-1:0] src_tag  [NS];

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    v_d    = v_q;
    last_d = last_q;
    data_d = data_q;
    key_d  = key_q;
    tag_d  = tag_q;

    en[NS-1] = !v_q[NS-1] | bus.OUT_READY;
    for (int i = NS - 2; i >= 0; i--) en[i] = !v_q[i] | en[i+1];

    src_v[0]    = bus.IN_VALID;
    src_data[0] = bus.IN_DATA;
    src_key[0]  = bus.IN_KEY;
    src_last[0] = bus.IN_LAST;
    src_tag[0]  = bus.IN_TAG;
    for (int i = 1; i < NS; i++) begin
      src_v[i]    = v_q[i-1];
      src_data[i] = data_q[i-1];
      src_key[i]  = key_q[i-1];
      src_last[i] = last_q[i-1];
      src_tag[i]  = tag_q[i-1];
    end

    // Payload loads only with a real beat so the output holds its last value across bubbles.
    for (int i = 0; i < NS; i++) begin
      if (en[i]) begin
        v_d[i] = src_v[i];
        if (src_v[i]) begin
          data_d[i] = apply_op(stage_op(i), src_data[i], src_key[i], src_last[i]);
          key_d[i]  = src_key[i];
          last_d[i] = src_last[i];
          tag_d[i]  = src_tag[i];
        end
      end
    end
  end

  // NOTE: only valid bits and the visible output stage are reset; inner payload is qualified by valid.
  // NOTE: state updates use <= so every stage samples its predecessor's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q            <= '0;
      data_q[NS-1]   <= '0;
      tag_q[NS-1]    <= '0;
    end else begin
      v_q    <= v_d;
      last_q <= last_d;
      data_q <= data_d;
      key_q  <= key_d;
      tag_q  <= tag_d;
    end
  end

  assign bus.IN_READY  = en[0];
  assign bus.OUT_VALID = v_q[NS-1];
  assign bus.OUT_DATA  = data_q[NS-1];
  assign bus.OUT_TAG   = tag_q[NS-1];
endmodule

// File: tb/tb_aes_round_pipe.sv
// Scoreboard bench for aes_round_pipe: runs every scenario on 1-, 2- and 3-stage instances in turn
// against an independently derived reference round (S-box built from GF(2^8) inverse + affine map).
module tb_aes_round_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_round_pipe_if #(.TAG_W(4)) if1 ();
  aes_round_pipe_if #(.TAG_W(4)) if2 ();
  aes_round_pipe_if #(.TAG_W(4)) if3 ();

  aes_round_pipe #(.PIPE_STAGES(1), .TAG_W(4)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  aes_round_pipe #(.PIPE_STAGES(2), .TAG_W(4)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  aes_round_pipe #(.PIPE_STAGES(3), .TAG_W(4)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  virtual aes_round_pipe_if #(.TAG_W(4)) vif;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   tag;
  } exp_t;

  exp_t         sb_q [$];
  logic [7:0]   sbox_m [256];
  logic [127:0] vin [2];
  logic [127:0] vkey [2];
  logic [127:0] vout [2];
  logic         vlast [2];
  int           checks = 0;
  int           errors = 0;
  int           ns;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] d, input logic [127:0] k,
                                             input logic l);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) s[rr][c] = sbox_m[d[127-8*(4*c+rr) -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) t[rr][c] = s[rr][(c+rr)%4];
    if (!l) begin
      for (int c = 0; c < 4; c++) begin
        s[0][c] = gmul(8'h02, t[0][c]) ^ gmul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
        s[1][c] = t[0][c] ^ gmul(8'h02, t[1][c]) ^ gmul(8'h03, t[2][c]) ^ t[3][c];
        s[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'h02, t[2][c]) ^ gmul(8'h03, t[3][c]);
        s[3][c] = gmul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'h02, t[3][c]);
      end
    end else begin
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[rr][c] = t[rr][c];
    end
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) r[127-8*(4*c+rr) -: 8] = s[rr][c];
    return r ^ k;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock cycle: apply inputs, sample handshakes at the falling edge, update the scoreboard.
  task automatic step(input logic iv, input logic [127:0] d, input logic [127:0] k,
                      input logic l, input logic [3:0] t, input logic ordy,
                      output logic acc, output logic ov, output logic [127:0] od,
                      output logic [3:0] ot);
    exp_t e;
    vif.IN_VALID  = iv;
    vif.IN_DATA   = d;
    vif.IN_KEY    = k;
    vif.IN_LAST   = l;
    vif.IN_TAG    = t;
    vif.OUT_READY = ordy;
    @(negedge clk);
    acc = vif.IN_VALID & vif.IN_READY;
    ov  = vif.OUT_VALID;
    od  = vif.OUT_DATA;
    ot  = vif.OUT_TAG;
    if (acc === 1'b1) begin
      e.data = ref_round(d, k, l);
      e.tag  = t;
      sb_q.push_back(e);
    end
    if ((ov & ordy) === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected stages=%0d got data=%h tag=%h, required no output", ns, od, ot);
      end else begin
        e = sb_q.pop_front();
        if (od !== e.data || ot !== e.tag) begin
          errors++;
          $display("FAIL sb_beat stages=%0d got data=%h tag=%h required data=%h tag=%h",
                   ns, od, ot, e.data, e.tag);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    logic acc, ov;
    logic [127:0] od;
    logic [3:0] ot;
    for (int c = 0; c < budget && sb_q.size() != 0; c++)
      step(1'b0, '0, '0, 1'b0, 4'h0, 1'b1, acc, ov, od, ot);
  endtask

  task automatic test_reset();
    vif.IN_VALID  = 1'b0;
    vif.OUT_READY = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    checks++;
    if (vif.OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid stages=%0d got %b required 0", ns, vif.OUT_VALID);
    end
    checks++;
    if (vif.OUT_DATA !== 128'h0) begin
      errors++; $display("FAIL reset_out_data stages=%0d got %h required 0", ns, vif.OUT_DATA);
    end
    checks++;
    if (vif.OUT_TAG !== 4'h0) begin
      errors++; $display("FAIL reset_out_tag stages=%0d got %h required 0", ns, vif.OUT_TAG);
    end
    checks++;
    if (vif.IN_READY !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready stages=%0d got %b required 1", ns, vif.IN_READY);
    end
  endtask

  task automatic test_vector(input int idx, input logic [3:0] tag);
    logic acc, ov, got;
    logic [127:0] od;
    logic [3:0] ot;
    int lat;
    step(1'b1, vin[idx], vkey[idx], vlast[idx], tag, 1'b1, acc, ov, od, ot);
    checks++;
    if (acc !== 1'b1) begin
      errors++; $display("FAIL vec%0d_accept stages=%0d got %b required 1", idx, ns, acc);
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      step(1'b0, '0, '0, 1'b0, 4'h0, 1'b1, acc, ov, od, ot);
      lat++;
      got = ov;
    end
    checks++;
    if (got !== 1'b1 || lat != ns) begin
      errors++; $display("FAIL vec%0d_latency stages=%0d got %0d cycles required %0d", idx, ns, lat, ns);
    end
    checks++;
    if (od !== vout[idx]) begin
      errors++; $display("FAIL vec%0d_data stages=%0d got %h required %h", idx, ns, od, vout[idx]);
    end
  endtask

  task automatic test_back_to_back();
    logic acc, ov;
    logic [127:0] od;
    logic [3:0] ot;
    int n_acc = 0, n_emit = 0, first = -1, last_e = -1;
    for (int c = 0; c < 8 + ns + 4; c++) begin
      step(c < 8, vin[c%2], vkey[c%2], vlast[c%2], 4'(c), 1'b1, acc, ov, od, ot);
      if (acc) n_acc++;
      if (ov) begin
        if (first < 0) first = c;
        last_e = c;
        n_emit++;
      end
    end
    checks++;
    if (n_acc != 8) begin
      errors++; $display("FAIL b2b_accepted stages=%0d got %0d required 8", ns, n_acc);
    end
    checks++;
    if (n_emit != 8 || last_e - first != 7 || first != ns) begin
      errors++;
      $display("FAIL b2b_burst stages=%0d got %0d beats over cycles %0d..%0d required 8 over %0d..%0d",
               ns, n_emit, first, last_e, ns, ns + 7);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL b2b_pending stages=%0d got %0d required 0", ns, sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic acc, ov, held = 1'b0, stable = 1'b1;
    logic [127:0] od, hd = '0;
    logic [3:0] ot, ht = '0;
    int n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, rand128(), rand128(), 1'($urandom_range(1)), 4'($urandom_range(15)), 1'b0,
           acc, ov, od, ot);
      if (acc) n_acc++;
      if (ov) begin
        if (!held) begin
          hd = od; ht = ot; held = 1'b1;
        end else if (od !== hd || ot !== ht) stable = 1'b0;
      end
    end
    checks++;
    if (n_acc != ns) begin
      errors++; $display("FAIL bp_accepted stages=%0d got %0d required %0d", ns, n_acc, ns);
    end
    checks++;
    if (vif.IN_READY !== 1'b0) begin
      errors++; $display("FAIL bp_in_ready stages=%0d got %b required 0", ns, vif.IN_READY);
    end
    checks++;
    if (!held || !stable) begin
      errors++; $display("FAIL bp_hold stages=%0d got held=%b stable=%b required 1/1", ns, held, stable);
    end
    // The release cycle emits the head beat and accepts one more in the same cycle.
    step(1'b1, rand128(), rand128(), 1'b0, 4'hf, 1'b1, acc, ov, od, ot);
    if (acc) n_acc++;
    checks++;
    if (n_acc != ns + 1) begin
      errors++; $display("FAIL bp_release stages=%0d got %0d required %0d", ns, n_acc, ns + 1);
    end
    drain(20);
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL bp_pending stages=%0d got %0d required 0", ns, sb_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    logic acc, ov;
    logic [127:0] od;
    logic [3:0] ot;
    int n_acc = 0, n_ov = 0;
    for (int c = 0; c < 2; c++) begin
      step(1'b1, vin[0], vkey[0], vlast[0], 4'(9 + c), 1'b0, acc, ov, od, ot);
      if (acc) n_acc++;
    end
    checks++;
    if (n_acc != ((ns >= 2) ? 2 : 1)) begin
      errors++; $display("FAIL mid_inflight stages=%0d got %0d required %0d", ns, n_acc, (ns >= 2) ? 2 : 1);
    end
    vif.IN_VALID = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    checks++;
    if (vif.OUT_VALID !== 1'b0 || vif.OUT_DATA !== 128'h0 || vif.OUT_TAG !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset_out stages=%0d got valid=%b data=%h tag=%h required 0/0/0",
               ns, vif.OUT_VALID, vif.OUT_DATA, vif.OUT_TAG);
    end
    for (int c = 0; c < 6; c++) begin
      step(1'b0, '0, '0, 1'b0, 4'h0, 1'b1, acc, ov, od, ot);
      if (ov) n_ov++;
    end
    checks++;
    if (n_ov != 0) begin
      errors++; $display("FAIL mid_discard stages=%0d got %0d stale beats required 0", ns, n_ov);
    end
    test_vector(0, 4'h5);
  endtask

  task automatic test_random(input int n);
    logic acc, ov;
    logic [127:0] od;
    logic [3:0] ot;
    int sent = 0, cyc = 0;
    while ((sent < n || sb_q.size() != 0) && cyc < 20 * n) begin
      step((sent < n) && ($urandom_range(3) != 0), rand128(), rand128(),
           1'($urandom_range(1)), 4'($urandom_range(15)), $urandom_range(3) != 0,
           acc, ov, od, ot);
      if (acc) sent++;
      cyc++;
    end
    checks++;
    if (sent != n || sb_q.size() != 0) begin
      errors++;
      $display("FAIL random_complete stages=%0d got sent=%0d pending=%0d required sent=%0d pending=0",
               ns, sent, sb_q.size(), n);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog stages=%0d got timeout required completion", ns);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    vin[0]  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    vkey[0] = 128'ha0fafe1788542cb123a339392a6c7605;
    vout[0] = 128'ha49c7ff2689f352b6b5bea43026a5049;
    vlast[0] = 1'b0;
    vin[1]  = 128'heb40f21e592e38848ba113e71bc342d2;
    vkey[1] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    vout[1] = 128'h3925841d02dc09fbdc118597196a0b32;
    vlast[1] = 1'b1;

    for (int cfg = 1; cfg <= 3; cfg++) begin
      if (cfg == 1) vif = if1;
      else if (cfg == 2) vif = if2;
      else vif = if3;
      vif.IN_VALID  = 1'b0;
      vif.IN_DATA   = '0;
      vif.IN_KEY    = '0;
      vif.IN_LAST   = 1'b0;
      vif.IN_TAG    = '0;
      vif.OUT_READY = 1'b0;
    end

    for (int cfg = 1; cfg <= 3; cfg++) begin
      ns = cfg;
      if (cfg == 1) vif = if1;
      else if (cfg == 2) vif = if2;
      else vif = if3;
      test_reset();
      test_vector(0, 4'h3);
      test_vector(1, 4'ha);
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      test_random(3334);
      vif.IN_VALID  = 1'b0;
      vif.OUT_READY = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
